// File: rtl/nios_ii_system_dual_port_memory.sv
// Dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) on one clock.
// Byte-lane writes, 1- or 2-cycle read latency with readdatavalid, wait-request
// during reset/clear/freeze, and an optional zero-fill sequence after reset.
//
// Ports:
//   clk, reset          sole clock; synchronous active-high reset
//   clken, reset_req    global enable and reset-request freeze (en = clken & ~reset_req)
//   sN_address          word address (ADDR_WIDTH)
//   sN_byteenable       write byte lanes (DATA_WIDTH/8)
//   sN_chipselect/read/write, sN_writedata   transfer request
//   sN_readdata, sN_readdatavalid            read response
//   sN_waitrequest      transfer stall (combinational, follows en immediately)
module nios_ii_system_dual_port_memory #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = "nios_ii_system_dual_port_memory.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;

  state_t           state, act_state, next_state;
  logic [IDX_W-1:0] clr_ptr;
  logic             en, waitrequest;

  // Power-up image is attached by the FPGA flow through this attribute.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Port 0 = s1, port 1 = s2.
  logic [ADDR_WIDTH-1:0] p_addr  [2];
  logic [BE_W-1:0]       p_be    [2];
  logic [DATA_WIDTH-1:0] p_wdata [2];
  logic [DATA_WIDTH-1:0] p_rword [2];
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [1:0]            p_cs, p_rd, p_wr, in_range, wr_acc, rd_acc, rvalid_q;

  assign p_addr[0]  = s1_address;    assign p_addr[1]  = s2_address;
  assign p_be[0]    = s1_byteenable; assign p_be[1]    = s2_byteenable;
  assign p_wdata[0] = s1_writedata;  assign p_wdata[1] = s2_writedata;
  assign p_cs       = {s2_chipselect, s1_chipselect};
  assign p_rd       = {s2_read, s1_read};
  assign p_wr       = {s2_write, s1_write};

  assign en          = clken & ~reset_req;
  assign waitrequest = reset | ~en | (act_state != S_READY);

  assign s1_waitrequest   = waitrequest;
  assign s2_waitrequest   = waitrequest;
  assign s1_readdata      = rdata_q[0];
  assign s2_readdata      = rdata_q[1];
  assign s1_readdatavalid = rvalid_q[0];
  assign s2_readdatavalid = rvalid_q[1];

  // RESET is only held while reset is asserted: the first cycle after reset
  // already behaves as CLEAR (clr_ptr = 0) or READY.
  always_comb begin
    act_state  = state;
    next_state = state;
    if (state == S_RESET) act_state = CLEAR_ON_RESET ? S_CLEAR : S_READY;
    next_state = act_state;
    if (act_state == S_CLEAR && clr_ptr == IDX_W'(DEPTH - 1)) next_state = S_READY;
  end

  // FSM state and clear pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RESET;
      clr_ptr <= '0;
    end else if (en) begin
      state <= next_state;
      if (act_state == S_CLEAR)
        clr_ptr <= (next_state == S_READY) ? '0 : clr_ptr + IDX_W'(1);
    end
  end

  // Transfer qualification; read+write together is a write only.
  always_comb begin
    in_range = '0;
    wr_acc   = '0;
    rd_acc   = '0;
    for (int p = 0; p < 2; p++) begin
      p_rword[p]  = '0;
      in_range[p] = 32'(p_addr[p]) < DEPTH;
      wr_acc[p]   = p_cs[p] & p_wr[p] & ~waitrequest;
      rd_acc[p]   = p_cs[p] & p_rd[p] & ~p_wr[p] & ~waitrequest;
      if (in_range[p]) p_rword[p] = mem[p_addr[p][IDX_W-1:0]];
    end
  end

  // RAM writes: s2 lanes are issued first so s1 overrides shared lanes.
  always_ff @(posedge clk) begin
    if (!reset && en) begin
      if (act_state == S_CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        for (int p = 1; p >= 0; p--) begin
          if (wr_acc[p] && in_range[p]) begin
            for (int b = 0; b < BE_W; b++) begin
              if (p_be[p][b]) mem[p_addr[p][IDX_W-1:0]][b*8 +: 8] <= p_wdata[p][b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read pipeline; valid drops while frozen so each response pulses once.
  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] stage_data [2];
      logic [1:0]            stage_valid;
      always_ff @(posedge clk) begin
        if (reset) begin
          stage_valid <= '0;
          rvalid_q    <= '0;
          for (int p = 0; p < 2; p++) begin
            stage_data[p] <= '0;
            rdata_q[p]    <= '0;
          end
        end else if (en) begin
          for (int p = 0; p < 2; p++) begin
            stage_valid[p] <= rd_acc[p];
            if (rd_acc[p]) stage_data[p] <= p_rword[p];
            rvalid_q[p] <= stage_valid[p];
            if (stage_valid[p]) rdata_q[p] <= stage_data[p];
          end
        end else begin
          rvalid_q <= '0;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (reset) begin
          rvalid_q <= '0;
          for (int p = 0; p < 2; p++) rdata_q[p] <= '0;
        end else begin
          for (int p = 0; p < 2; p++) begin
            rvalid_q[p] <= rd_acc[p];
            if (rd_acc[p]) rdata_q[p] <= p_rword[p];
          end
        end
      end
    end
  endgenerate

endmodule

// File: doc/nios_ii_system_dual_port_memory.md
# nios_ii_system_dual_port_memory

Parametrised dual-port on-chip memory with two independent Avalon-MM slaves (s1, s2) on one clock. Generalises the single-port on-chip RAM with configurable width/depth, selectable read latency with `readdatavalid`, explicit wait-request, and an optional zero-fill sequence after reset. Sits on the Nios II system interconnect as program/data memory, or as a shared buffer between the CPU and a DMA/video master.

## Interface
- `DATA_WIDTH`, 32: word width in bits; multiple of 8.
- `ADDR_WIDTH`, 10: word-address width per port.
- `DEPTH`, 1024: words implemented; must be ≤ 2^ADDR_WIDTH.
- `READ_LATENCY`, 1: cycles from accepted read to `readdatavalid`; legal values are 1 and 2.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill all words after reset; 0 = keep contents (INIT_FILE image only at configuration).
- `INIT_FILE`, "nios_ii_system_dual_port_memory.hex": power-up image.
- `clk` in 1: sole clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `clken` in 1: global clock enable.
- `reset_req` in 1: reset-request freeze, high from the CPU reset controller.
- `s1_address` / `s2_address` in ADDR_WIDTH: word address.
- `s1_byteenable` / `s2_byteenable` in DATA_WIDTH/8: write byte lanes.
- `s1_chipselect`, `s1_read`, `s1_write` in 1 (likewise for s2): transfer qualifiers.
- `s1_writedata` / `s2_writedata` in DATA_WIDTH: write data.
- `s1_readdata` / `s2_readdata` out DATA_WIDTH: read data.
- `s1_readdatavalid` / `s2_readdatavalid` out 1: readdata qualifier.
- `s1_waitrequest` / `s2_waitrequest` out 1: transfer stall.

## Operation
- Define `en = clken & ~reset_req`. When `en` is low:
  - the RAM, read pipeline and FSM hold state;
  - both `waitrequest` outputs are high.
- FSM states:
  - **RESET**: entered while `reset` is high.
  - **CLEAR**: entered on the first cycle after reset when `CLEAR_ON_RESET=1`. Writes zero to address `clr_ptr`, one word per `en` cycle, for `clr_ptr` = 0..DEPTH-1. Exits after DEPTH-1 is written.
  - **READY**: entered after CLEAR, or directly from RESET when `CLEAR_ON_RESET=0`.
- `waitrequest` is high in RESET, high in CLEAR, and high whenever `en` is low. Otherwise it is 0.
- A transfer is accepted when `chipselect & (read|write) & ~waitrequest`.
- Write:
  - Only the lanes with `byteenable` set are updated.
  - An address ≥ DEPTH is dropped silently.
- Read:
  - An accepted read returns the word READ_LATENCY `en` cycles later, with `readdatavalid` high for exactly one cycle.
  - An address ≥ DEPTH returns 0, still with valid.
- `read` and `write` asserted together: the write is performed, no read is issued and `readdatavalid` is not pulsed.
- Both ports write the same in-range address in the same cycle: s1 data wins on every lane s1 enables. s2 writes only the lanes s1 does not enable.
- Read-during-write on the same address, same or opposite port: the read returns the old data.
- `readdata` holds its last value while `readdatavalid` is low.
- Reset mid-CLEAR or mid-read:
  - In-flight reads are discarded; no `readdatavalid` follows.
  - `clr_ptr` returns to 0 and CLEAR restarts.
  - RAM contents are not guaranteed until CLEAR completes.

## Timing
- Reset values:
  - `readdata` = 0, `readdatavalid` = 0, `waitrequest` = 1 (both ports);
  - FSM = RESET, `clr_ptr` = 0.
- CLEAR lasts exactly DEPTH `en` cycles. `waitrequest` falls on the cycle after the last clear write.
- With `CLEAR_ON_RESET=0`, `waitrequest` falls on the first cycle after `reset` deasserts.
- With `en` held high, the read pipeline is fully pipelined: one read per port per cycle.
- `READ_LATENCY=1`: read accepted at edge N, data valid in cycle N+1.
- `READ_LATENCY=2`: read accepted at edge N, data valid in cycle N+2 (registered output).
- A write at edge N is visible to any read accepted at edge N+1 or later.

## Test plan
- Reset clear: reset for 2 cycles with DEPTH=16, CLEAR_ON_RESET=1 → `waitrequest` high for exactly 16 cycles after reset. Reads of addresses 0..15 then return 0x00000000.
- Byte lanes and latency: s1 writes 0xAABBCCDD to address 5 with byteenable=4'b0101, over prior 0. Then s1 reads address 5 → readdata 0x00BB00DD, valid at +1 cycle with READ_LATENCY=1 and at +2 with READ_LATENCY=2.
- Collision: same cycle, s1 writes 0x11111111 with be=4'b0011 and s2 writes 0x22222222 with be=4'b1111, both to address 3 → read returns 0x22221111.
- Read-during-write: s2 reads address 7 (holding 0x5) while s1 writes 0x9 to it → s2 gets 0x5. The next s2 read of address 7 gets 0x9.
- Stall: issue back-to-back reads of addresses 1,2,3, drop `clken` for 3 cycles mid-stream, and pulse `reset_req` once → no reads are lost or duplicated. Valids arrive in order 1,2,3 with the pipeline frozen during the stall. Read address DEPTH → data 0 with valid.
- Reset mid-operation: assert `reset` during CLEAR at `clr_ptr`=9 and with a read in flight → no `readdatavalid` follows. CLEAR restarts at 0 and runs a full DEPTH cycles.
